// File: rtl/bcd_ascii_pkg.sv
// bcd_ascii_pkg
// Shared types and helpers for the BCD-to-ASCII character serializer.
//   state_t         : serializer FSM states
//   ASCII_*         : character codes used by the serializer
//   digit_to_ascii  : maps one BCD digit to its ASCII character ('?' if > 9)
package bcd_ascii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        TERM = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        logic [7:0] c;
        if (d <= 4'd9) begin
            c = ASCII_ZERO + {4'h0, d};
        end else begin
            c = ASCII_QMARK;
        end
        return c;
    endfunction

endpackage

// File: rtl/leading_digit_finder.sv
// leading_digit_finder
// Combinational priority encoder over a packed BCD digit vector.
//   bcd     : packed digits, digit 0 least significant
//   index   : position of the most significant nonzero digit (0 if all zero)
//   invalid : high if any digit is greater than 9
module leading_digit_finder #(
    parameter int unsigned NDIGITS = 10,
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic [NDIGITS-1:0][3:0] bcd,
    output logic [IW-1:0]           index,
    output logic                    invalid
);

    // Ascending scan: the last nonzero digit seen is the most significant one.
    always_comb begin
        index   = '0;
        invalid = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd[i] != 4'd0) begin
                index = IW'(i);
            end
            if (bcd[i] > 4'd9) begin
                invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer
// Captures a BCD digit vector on Load, suppresses leading zeros and streams
// the remaining digits as ASCII over a valid/ready handshake, optionally
// followed by a line feed.
//   Clock     : rising-edge clock
//   Reset     : synchronous active-high reset
//   Load      : one-cycle capture strobe for BCD (ignored while Busy)
//   BCD       : packed digits, digit 0 least significant
//   Char      : current ASCII character (registered)
//   CharValid : Char is valid (registered)
//   CharReady : sink accepts Char
//   Busy      : a number is being streamed
//   Done      : one-cycle pulse after the final character transfers
//   Error     : captured number contained a digit greater than 9
//   Overrun   : one-cycle pulse after a Load arrived while Busy
module bcd_ascii_serializer
    import bcd_ascii_pkg::*;
#(
    parameter int unsigned NDIGITS = 10,
    parameter bit          TERM_EN = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Load,
    input  logic [NDIGITS-1:0][3:0] BCD,
    output logic [7:0]              Char,
    output logic                    CharValid,
    input  logic                    CharReady,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Error,
    output logic                    Overrun
);

    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_t                  state_q, state_d;
    logic [NDIGITS-1:0][3:0] digits_q, digits_d;
    logic [IW-1:0]           index_q, index_d;
    logic [IW-1:0]           index_dec;
    logic [7:0]              char_q, char_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    logic [IW-1:0]           lead_index;
    logic                    lead_invalid;
    logic                    xfer;

    leading_digit_finder #(
        .NDIGITS(NDIGITS)
    ) u_finder (
        .bcd     (BCD),
        .index   (lead_index),
        .invalid (lead_invalid)
    );

    assign xfer      = valid_q & CharReady;
    assign index_dec = index_q - 1'b1;

    // Char is registered, so the next character is looked up one step ahead:
    // on load from the incoming vector, on each transfer from index-1.
    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        index_d   = index_q;
        char_d    = char_q;
        valid_d   = valid_q;
        error_d   = error_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Load) begin
                    digits_d = BCD;
                    index_d  = lead_index;
                    error_d  = lead_invalid;
                    char_d   = digit_to_ascii(BCD[lead_index]);
                    valid_d  = 1'b1;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                overrun_d = Load;
                if (xfer) begin
                    if (index_q != '0) begin
                        index_d = index_dec;
                        char_d  = digit_to_ascii(digits_q[index_dec]);
                    end else if (TERM_EN) begin
                        char_d  = ASCII_LF;
                        state_d = TERM;
                    end else begin
                        char_d  = 8'h00;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            TERM: begin
                overrun_d = Load;
                if (xfer) begin
                    char_d  = 8'h00;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                char_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            index_q   <= '0;
            char_q    <= 8'h00;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            index_q   <= index_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign Char      = char_q;
    assign CharValid = valid_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign Error     = error_q;
    assign Overrun   = overrun_q;

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// tb_bcd_ascii_serializer
// Directed bench for bcd_ascii_serializer. Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
module tb_bcd_ascii_serializer;

    logic             Clock;
    logic             Reset;
    logic             Load;
    logic [9:0][3:0]  BCD;
    logic [7:0]       Char;
    logic             CharValid;
    logic             CharReady;
    logic             Busy;
    logic             Done;
    logic             Error;
    logic             Overrun;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    bcd_ascii_serializer #(
        .NDIGITS (10),
        .TERM_EN (1'b1)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (Load),
        .BCD       (BCD),
        .Char      (Char),
        .CharValid (CharValid),
        .CharReady (CharReady),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .Overrun   (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Load one number and follow the whole stream; every cycle the current
    // character must equal the next expected one, so a drop, duplicate or
    // change while stalled shows up as a wrong character.
    task automatic stream_check(input string tag, input logic [39:0] bcd,
                                input string exp, input bit toggle, input bit exp_err);
        int unsigned idx;
        int unsigned budget;
        logic [7:0]  e;
        BCD  = bcd;
        Load = 1'b1;
        step();
        Load      = 1'b0;
        CharReady = toggle ? 1'b0 : 1'b1;
        check_eq({tag, "_busy"}, {31'h0, Busy}, 32'h1);
        idx    = 0;
        budget = 0;
        while (idx < exp.len() && budget < 200) begin
            e = exp[idx];
            check_eq({tag, "_valid"}, {31'h0, CharValid}, 32'h1);
            check_eq({tag, "_char"}, {24'h0, Char}, {24'h0, e});
            check_eq({tag, "_nodone"}, {31'h0, Done}, 32'h0);
            if (CharReady) idx++;
            step();
            if (toggle) CharReady = ~CharReady;
            budget++;
        end
        if (budget >= 200) check_eq({tag, "_timeout"}, 32'h0, 32'h1);
        check_eq({tag, "_done"}, {31'h0, Done}, 32'h1);
        check_eq({tag, "_idle"}, {31'h0, Busy}, 32'h0);
        check_eq({tag, "_validlow"}, {31'h0, CharValid}, 32'h0);
        check_eq({tag, "_error"}, {31'h0, Error}, {31'h0, exp_err});
        CharReady = 1'b1;
    endtask

    initial begin
        Reset     = 1'b1;
        Load      = 1'b0;
        BCD       = '0;
        CharReady = 1'b0;
        step();
        step();
        check_eq("rst_char", {24'h0, Char}, 32'h0);
        check_eq("rst_valid", {31'h0, CharValid}, 32'h0);
        check_eq("rst_busy", {31'h0, Busy}, 32'h0);
        check_eq("rst_done", {31'h0, Done}, 32'h0);
        check_eq("rst_error", {31'h0, Error}, 32'h0);
        check_eq("rst_overrun", {31'h0, Overrun}, 32'h0);
        Reset = 1'b0;
        step();
        check_eq("idle_busy", {31'h0, Busy}, 32'h0);

        // 255 with ready high: "255\n" on consecutive cycles, Done at t+5
        stream_check("s255", 40'h0000000255, "255\n", 1'b0, 1'b0);
        // all zero: single "0" is not suppressed
        stream_check("s0", 40'h0000000000, "0\n", 1'b0, 1'b0);
        // full width with ready toggling every cycle
        stream_check("smax", 40'h4294967295, "4294967295\n", 1'b1, 1'b0);

        // Overrun mid-stream and on the final-transfer cycle
        BCD  = 40'h0000000255;
        Load = 1'b1;
        CharReady = 1'b1;
        step();
        check_eq("ov_c1_char", {24'h0, Char}, 32'h32);
        BCD  = 40'h9999999999;
        Load = 1'b1;
        step();
        Load = 1'b0;
        check_eq("ov_c2_char", {24'h0, Char}, 32'h35);
        check_eq("ov_c2_pulse", {31'h0, Overrun}, 32'h1);
        step();
        check_eq("ov_c3_char", {24'h0, Char}, 32'h35);
        check_eq("ov_c3_nopulse", {31'h0, Overrun}, 32'h0);
        step();
        check_eq("ov_c4_char", {24'h0, Char}, 32'h0A);
        Load = 1'b1;
        step();
        Load = 1'b0;
        check_eq("ov_c5_done", {31'h0, Done}, 32'h1);
        check_eq("ov_c5_pulse", {31'h0, Overrun}, 32'h1);
        check_eq("ov_c5_busy", {31'h0, Busy}, 32'h0);
        check_eq("ov_c5_valid", {31'h0, CharValid}, 32'h0);
        step();
        check_eq("ov_c6_busy", {31'h0, Busy}, 32'h0);
        check_eq("ov_c6_pulse", {31'h0, Overrun}, 32'h0);
        check_eq("ov_c6_done", {31'h0, Done}, 32'h0);

        // invalid digit: "1?3\n", Error sticky while idle
        stream_check("sinv", 40'h00000001B3, "1?3\n", 1'b0, 1'b1);
        step();
        step();
        check_eq("err_hold", {31'h0, Error}, 32'h1);

        // Reset mid-stream after two transfers
        BCD  = 40'h0000012345;
        Load = 1'b1;
        CharReady = 1'b1;
        step();
        Load = 1'b0;
        check_eq("rs_c1_char", {24'h0, Char}, 32'h31);
        check_eq("rs_err_clear", {31'h0, Error}, 32'h0);
        step();
        check_eq("rs_c2_char", {24'h0, Char}, 32'h32);
        step();
        check_eq("rs_c3_char", {24'h0, Char}, 32'h33);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_eq("rs_valid", {31'h0, CharValid}, 32'h0);
        check_eq("rs_busy", {31'h0, Busy}, 32'h0);
        check_eq("rs_char", {24'h0, Char}, 32'h0);
        check_eq("rs_done", {31'h0, Done}, 32'h0);
        step();
        check_eq("rs_done2", {31'h0, Done}, 32'h0);
        check_eq("rs_valid2", {31'h0, CharValid}, 32'h0);

        stream_check("safter", 40'h0000000907, "907\n", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_ascii_serializer.md
# bcd_ascii_serializer

Downstream consumer of the DoubleDabble converter. Captures a packed BCD digit vector when the converter signals completion. Suppresses leading zeros and streams the remaining digits as ASCII characters, one per transfer, over a valid/ready handshake, optionally followed by a line-feed terminator. Feeds a UART transmitter or character-based log sink.

## Interface

- NDIGITS, 10: number of BCD digits captured; 10 covers a 32-bit binary input.
- TERM_EN, 1: when 1, emit 8'h0A after the last digit.

- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- Load  input  1  one-cycle pulse from the upstream Ready; captures BCD.
- BCD  input  [NDIGITS-1:0][3:0]  packed digits; digit 0 is least significant.
- Char  output  8  current ASCII character.
- CharValid  output  1  Char is valid.
- CharReady  input  1  sink accepts Char.
- Busy  output  1  a number is being streamed; Load is ignored while high.
- Done  output  1  one-cycle pulse after the final character transfers.
- Error  output  1  the captured number contained a digit greater than 9.
- Overrun  output  1  one-cycle pulse when Load arrives while Busy is high.

## Operation

- States: IDLE, EMIT, TERM. Busy = (state != IDLE).
- IDLE, Load=1:
  - Register BCD.
  - Index = position of the most significant nonzero digit, found combinationally on the incoming BCD; 0 if all digits are zero.
  - Error = 1 if any digit > 4'd9, else 0.
  - Next state is EMIT.
- Load=0 in IDLE: no state change.
- EMIT:
  - Char = 8'h30 + digit[Index] when digit ≤ 9; otherwise 8'h3F ('?').
  - CharValid = 1.
  - On transfer (CharValid & CharReady at the rising edge) with Index > 0: decrement Index.
  - On transfer with Index = 0: go to TERM if TERM_EN, else IDLE.
- TERM: Char = 8'h0A, CharValid = 1. On transfer, go to IDLE.
- Done pulses in the first cycle back in IDLE.
- Load while Busy:
  - Ignored; the captured data is unchanged.
  - Overrun pulses in the next cycle.
  - This also applies when Load coincides with the final transfer: Busy is still high in that cycle.
- Error holds until the next accepted Load or Reset.
- All-zero input emits the single character "0" and is not suppressed.

## Timing

- Reset values: state IDLE, Char 8'h00, CharValid 0, Busy 0, Done 0, Error 0, Overrun 0, Index 0.
- Reset has priority over every other input. Reset mid-stream aborts: no further characters, and no Done pulse.
- Load accepted at edge t: CharValid is high from cycle t+1.
- Char and CharValid are registered. They are held stable while CharReady is low; the sink may stall indefinitely.
- With CharReady held high: k digits plus terminator occupy cycles t+1 through t+k+1. Done and Busy=0 occur in cycle t+k+2. The next Load is accepted in that same cycle.
- No combinational path from CharReady to CharValid or Char.

## Structure

- Shared package bcd_ascii_pkg holds:
  - state enum typedef;
  - ASCII_ZERO = 8'h30, ASCII_LF = 8'h0A, ASCII_QMARK = 8'h3F;
  - a digit-to-ASCII function.
- One sub-module, leading_digit_finder:
  - combinational priority encoder, parameter NDIGITS;
  - outputs the index of the most significant nonzero digit, plus an any-invalid flag.
- Index width is $clog2(NDIGITS).

## Test plan

- BCD 0000000255, Load, CharReady=1 -> Char sequence 8'h32, 8'h35, 8'h35, 8'h0A on consecutive cycles; Done in cycle t+5; Error=0.
- BCD 0, Load -> 8'h30, 8'h0A; Done in cycle t+3.
- BCD 4294967295, CharReady toggled 1/0 every cycle -> all 10 digits plus LF, each held stable while stalled, none dropped or duplicated; Done after the final LF transfer.
- Second Load during streaming and on the final-transfer cycle -> Overrun pulses each time; the output stream is unchanged.
- Digit pattern containing 4'hB, e.g. 0x00000001B3 -> "1?3\n"; Error=1 until the next Load of valid data.
- Reset asserted mid-stream after two characters -> next cycle CharValid=0, Busy=0, Char=8'h00, no Done; a following Load streams correctly.
